// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel-enable divider, h/v counters, sync/blank decode and a pixel-tick delay line.
// Optional VGA_SYNC_FRAME_CNT_EN adds a 16-bit frame counter output (frame_cnt).
module vga_sync_gen #(
    parameter int CLK_DIV    = 4,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_POL   = 0,
    parameter int PIPE_DELAY = 2
) (
    input  logic        clk_fpga,
    input  logic        reset,
    output logic        pix_en,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        line_start,
    output logic        frame_start,
    output logic        blank,
    output logic        HS,
`ifdef VGA_SYNC_FRAME_CNT_EN
    output logic        VS,
    output logic [15:0] frame_cnt
`else
    output logic        VS
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic POL   = (SYNC_POL != 0);
    localparam logic [2:0] PIPE_RST = {1'b1, ~POL, ~POL};

    logic [DIV_W-1:0] div_q, div_d;
    logic [10:0]      hcount_q, hcount_d;
    logic [10:0]      vcount_q, vcount_d;
    logic             h_last, v_last;
    logic             hs_act, vs_act;
    logic [2:0]       raw;

    assign pix_en = (div_q == DIV_W'(CLK_DIV - 1));
    assign h_last = (hcount_q == 11'(H_TOTAL - 1));
    assign v_last = (vcount_q == 11'(V_TOTAL - 1));

    always_comb begin
        div_d    = pix_en ? '0 : div_q + DIV_W'(1);
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en) begin
            hcount_d = h_last ? 11'd0 : hcount_q + 11'd1;
            if (h_last) begin
                vcount_d = v_last ? 11'd0 : vcount_q + 11'd1;
            end
        end
    end

    always_ff @(posedge clk_fpga or posedge reset) begin
        if (reset) begin
            div_q    <= '0;
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            div_q    <= div_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign line_start  = pix_en && (hcount_q == 11'd0);
    assign frame_start = pix_en && (hcount_q == 11'd0) && (vcount_q == 11'd0);

    assign hs_act = (hcount_q >= 11'(H_ACTIVE + H_FP)) && (hcount_q < 11'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_act = (vcount_q >= 11'(V_ACTIVE + V_FP)) && (vcount_q < 11'(V_ACTIVE + V_FP + V_SYNC));

    // raw = {blank, HS, VS} at sync output levels
    always_comb begin
        raw[2] = (hcount_q >= 11'(H_ACTIVE)) || (vcount_q >= 11'(V_ACTIVE));
        raw[1] = hs_act ? POL : ~POL;
        raw[0] = vs_act ? POL : ~POL;
    end

    generate
        if (PIPE_DELAY == 0) begin : g_nodelay
            assign {blank, HS, VS} = raw;
        end else begin : g_delay
            logic [2:0] pipe_q [PIPE_DELAY];
            logic [2:0] pipe_d [PIPE_DELAY];

            always_comb begin
                for (int i = 0; i < PIPE_DELAY; i++) begin
                    pipe_d[i] = pipe_q[i];
                end
                if (pix_en) begin
                    pipe_d[0] = raw;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        pipe_d[i] = pipe_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk_fpga or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        pipe_q[i] <= PIPE_RST;
                    end
                end else begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        pipe_q[i] <= pipe_d[i];
                    end
                end
            end

            assign {blank, HS, VS} = pipe_q[PIPE_DELAY-1];
        end
    endgenerate

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    assign frame_cnt_d = frame_start ? frame_cnt_q + 16'd1 : frame_cnt_q;

    always_ff @(posedge clk_fpga or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen on a shrunken raster; expected outputs are derived
// arithmetically from the number of clock edges seen since the last reset release.
`timescale 1ns/1ps
module tb_vga_sync_gen;

    localparam int CD  = 4;
    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HSW = 3;
    localparam int HBP = 2;
    localparam int VA  = 6;
    localparam int VFP = 1;
    localparam int VSW = 2;
    localparam int VBP = 1;
    localparam int POL = 0;
    localparam int PD  = 2;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int FRAME_CLKS = HT * VT * CD;
    localparam int NCYC = 8000;
`ifdef VGA_SYNC_FRAME_CNT_EN
    localparam int W = 44;
`else
    localparam int W = 28;
`endif

    typedef struct {
        int           n;
        logic [W-1:0] v;
    } exp_t;

    logic        clk_fpga = 1'b0;
    logic        reset    = 1'b1;
    logic        pix_en, line_start, frame_start, blank, HS, VS;
    logic [10:0] hcount, vcount;
    logic [W-1:0] got;
    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          drv_done = 1'b0;

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    assign got = {pix_en, line_start, frame_start, blank, HS, VS, hcount, vcount, frame_cnt};
`else
    assign got = {pix_en, line_start, frame_start, blank, HS, VS, hcount, vcount};
`endif

    vga_sync_gen #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POL(POL), .PIPE_DELAY(PD)
    ) dut (
        .clk_fpga   (clk_fpga),
        .reset      (reset),
        .pix_en     (pix_en),
        .hcount     (hcount),
        .vcount     (vcount),
        .line_start (line_start),
        .frame_start(frame_start),
        .blank      (blank),
        .HS         (HS),
`ifdef VGA_SYNC_FRAME_CNT_EN
        .VS         (VS),
        .frame_cnt  (frame_cnt)
`else
        .VS         (VS)
`endif
    );

    always #5 clk_fpga = ~clk_fpga;

    // Reference: n clock edges since release -> n/CD pixel ticks -> raster position.
    function automatic logic [W-1:0] model(input int n);
        int   t, h, v, s, sh, sv;
        logic pe, ls, fs, bl, hs, vs;
        t  = n / CD;
        h  = t % HT;
        v  = (t / HT) % VT;
        pe = ((n % CD) == CD - 1);
        ls = pe && (h == 0);
        fs = pe && (h == 0) && (v == 0);
        if (t >= PD) begin
            s  = t - PD;
            sh = s % HT;
            sv = (s / HT) % VT;
            bl = (sh >= HA) || (sv >= VA);
            hs = ((sh >= HA + HFP) && (sh < HA + HFP + HSW)) ? (POL != 0) : (POL == 0);
            vs = ((sv >= VA + VFP) && (sv < VA + VFP + VSW)) ? (POL != 0) : (POL == 0);
        end else begin
            bl = 1'b1;
            hs = (POL == 0);
            vs = (POL == 0);
        end
`ifdef VGA_SYNC_FRAME_CNT_EN
        begin
            int fc;
            fc = (n >= CD) ? ((n - CD) / FRAME_CLKS + 1) : 0;
            return {pe, ls, fs, bl, hs, vs, 11'(h), 11'(v), 16'(fc % 65536)};
        end
`else
        return {pe, ls, fs, bl, hs, vs, 11'(h), 11'(v)};
`endif
    endfunction

    // Driver: steps reset (including random mid-frame assertions) and pushes expectations.
    initial begin
        int n, rst_hold, next_rst;
        exp_t e;
        n        = 0;
        rst_hold = 9;
        next_rst = 10 + 2 * FRAME_CLKS + $urandom_range(0, 400);
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk_fpga);
            #1;
            if (!reset) n++;
            #1;
            if (reset) begin
                if (rst_hold > 0) rst_hold--;
                else reset = 1'b0;
            end else if (c == next_rst) begin
                reset    = 1'b1;
                rst_hold = $urandom_range(0, 4);
                next_rst = c + $urandom_range(300, 1500);
            end
            if (reset) n = 0;
            e.n = n;
            e.v = model(n);
            exp_q.push_back(e);
        end
        drv_done = 1'b1;
    end

    // Monitor: compares the DUT against each pending expectation away from the active edge.
    always @(negedge clk_fpga) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL outputs n=%0d rst=%0b got=%h expected=%h", e.n, reset, got, e.v);
            end
        end
    end

    initial begin
        int guard;
        guard = 0;
        while (!(drv_done && exp_q.size() == 0) && guard < NCYC + 100) begin
            @(negedge clk_fpga);
            guard++;
        end
        #1;
        if (!(drv_done && exp_q.size() == 0)) begin
            errors++;
            $display("FAIL drain got=%0d expected=0 pending", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
